// File: rtl/fpu_pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP unit among NREQ requesters.
// A LAT-deep {valid, owner, tag} shadow pipe routes each result back to its owner.
module fpu_pipe_arbiter #(
  parameter int NREQ  = 2,
  parameter int LAT   = 5,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*32-1:0]         req_x,
  input  logic [NREQ*32-1:0]         req_y,
  input  logic [NREQ*TAG_W-1:0]      req_tag,
  input  logic [NREQ-1:0]            flush,
  output logic                       unit_valid,
  output logic [31:0]                unit_x,
  output logic [31:0]                unit_y,
  input  logic [31:0]                unit_res,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [31:0]                rsp_data,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       busy,
  output logic [$clog2(LAT+1)-1:0]   inflight
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LAT+1);

  logic [PW-1:0]                ptr_q, ptr_d;
  logic [LAT-1:0]               vld_q, vld_d;
  logic [LAT-1:0][PW-1:0]       own_q, own_d;
  logic [LAT-1:0][TAG_W-1:0]    tag_q, tag_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  logic [NREQ-1:0] elig;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;

  // A flushed requester is ineligible, so the grant never lands on it.
  always_comb begin
    int idx;
    idx     = 0;
    elig    = rst ? '0 : (req_valid & ~flush);
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    req_ready  = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    unit_valid = gnt_any;
    unit_x     = gnt_any ? req_x[gnt_idx*32 +: 32] : 32'h0;
    unit_y     = gnt_any ? req_y[gnt_idx*32 +: 32] : 32'h0;
    ptr_d      = gnt_any ? PW'((int'(gnt_idx) + 1) % NREQ) : ptr_q;
  end

  // Flush kills matching entries as they shift, so they become bubbles next cycle.
  always_comb begin
    vld_d    = '0;
    own_d    = '0;
    tag_d    = '0;
    vld_d[0] = gnt_any;
    own_d[0] = gnt_idx;
    tag_d[0] = gnt_any ? req_tag[gnt_idx*TAG_W +: TAG_W] : '0;
    for (int j = 1; j < LAT; j++) begin
      vld_d[j] = vld_q[j-1] & ~flush[own_q[j-1]];
      own_d[j] = own_q[j-1];
      tag_d[j] = tag_q[j-1];
    end
    cnt_d = '0;
    for (int j = 0; j < LAT; j++) cnt_d = cnt_d + CW'(vld_d[j]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      vld_q <= '0;
      own_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      own_q <= own_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_tag   = '0;
    if (!rst && vld_q[LAT-1] && !flush[own_q[LAT-1]]) begin
      rsp_valid[own_q[LAT-1]] = 1'b1;
      rsp_tag                 = tag_q[LAT-1];
    end
  end

  assign rsp_data = unit_res;
  assign inflight = cnt_q;
  assign busy     = (cnt_q != '0);
endmodule

// File: tb/tb_fpu_pipe_arbiter.sv
// Bench for fpu_pipe_arbiter: directed vector table, contention/streaming sequences,
// and random traffic checked against a queue-based model of issued operations.
module tb_fpu_pipe_arbiter;
  localparam int NREQ = 2, LAT = 5, TAG_W = 4;

  logic                    clk, rst;
  logic [NREQ-1:0]         req_valid, req_ready, flush, rsp_valid;
  logic [NREQ*32-1:0]      req_x, req_y;
  logic [NREQ*TAG_W-1:0]   req_tag;
  logic                    unit_valid, busy;
  logic [31:0]             unit_x, unit_y, unit_res, rsp_data;
  logic [TAG_W-1:0]        rsp_tag;
  logic [2:0]              inflight;

  fpu_pipe_arbiter #(.NREQ(NREQ), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag), .flush(flush),
    .unit_valid(unit_valid), .unit_x(unit_x), .unit_y(unit_y), .unit_res(unit_res),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy), .inflight(inflight));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fu(input logic [31:0] a, input logic [31:0] b);
    return (a * 32'd3) ^ {b[15:0], b[31:16]};
  endfunction

  // Stand-in shared unit: fixed LAT-cycle pipeline, never reset.
  logic [31:0] upipe [LAT];
  always @(posedge clk) begin
    upipe[0] <= unit_valid ? fu(unit_x, unit_y) : 32'hdead_beef;
    for (int k = 1; k < LAT; k++) upipe[k] <= upipe[k-1];
  end
  assign unit_res = upipe[LAT-1];

  typedef struct {int issue; int due; int owner; logic [TAG_W-1:0] tag; logic [31:0] data;} ent_t;
  ent_t q[$];
  int pm, cyc, chks, errs, g_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    logic [1:0] ersp;
    logic [3:0] etag;
    logic [31:0] edata;
    int inf;
    g_m = -1;
    if (!rst)
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (pm + k) % NREQ;
        if (g_m < 0 && req_valid[i] && !flush[i]) g_m = i;
      end
    chk("m_ready", 32'(req_ready), (g_m >= 0) ? (32'd1 << g_m) : 32'd0);
    chk("m_unit_valid", 32'(unit_valid), 32'(g_m >= 0));
    chk("m_unit_x", unit_x, (g_m >= 0) ? req_x[g_m*32 +: 32] : 32'd0);
    chk("m_unit_y", unit_y, (g_m >= 0) ? req_y[g_m*32 +: 32] : 32'd0);
    ersp = 0; etag = 0; edata = 0; inf = 0;
    foreach (q[n]) begin
      if (q[n].issue < cyc && cyc <= q[n].due) inf++;
      if (q[n].due == cyc && !rst && !flush[q[n].owner]) begin
        ersp[q[n].owner] = 1'b1;
        etag  = q[n].tag;
        edata = q[n].data;
      end
    end
    chk("m_rsp_valid", 32'(rsp_valid), 32'(ersp));
    chk("m_rsp_tag", 32'(rsp_tag), 32'(etag));
    if (ersp != 0) chk("m_rsp_data", rsp_data, edata);
    chk("m_inflight", 32'(inflight), 32'(inf));
    chk("m_busy", 32'(busy), 32'(inf != 0));
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] f,
                       input logic [3:0] t0, input logic [3:0] t1,
                       input logic [31:0] x0, input logic [31:0] y0,
                       input logic [31:0] x1, input logic [31:0] y1);
    rst = r; req_valid = v; flush = f;
    req_tag = {t1, t0}; req_x = {x1, x0}; req_y = {y1, y0};
    #2;
    model_check();
  endtask

  task automatic tick();
    ent_t e;
    if (rst) begin
      q.delete();
      pm = 0;
    end else begin
      for (int n = q.size() - 1; n >= 0; n--)
        if (q[n].due <= cyc || flush[q[n].owner]) q.delete(n);
      if (g_m >= 0) begin
        e.issue = cyc; e.due = cyc + LAT; e.owner = g_m;
        e.tag   = req_tag[g_m*TAG_W +: TAG_W];
        e.data  = fu(req_x[g_m*32 +: 32], req_y[g_m*32 +: 32]);
        q.push_back(e);
        pm = (g_m + 1) % NREQ;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  typedef struct {logic r; logic [1:0] v; logic [1:0] f; logic [3:0] t0; logic [3:0] t1;
                  logic [1:0] rdy; logic [1:0] rsp; logic [3:0] tag; int inf;} vec_t;
  vec_t tv[$];

  function automatic vec_t mk(logic r, logic [1:0] v, logic [1:0] f, logic [3:0] t0, logic [3:0] t1,
                              logic [1:0] rdy, logic [1:0] rsp, logic [3:0] tag, int inf);
    vec_t e;
    e.r = r; e.v = v; e.f = f; e.t0 = t0; e.t1 = t1;
    e.rdy = rdy; e.rsp = rsp; e.tag = tag; e.inf = inf;
    return e;
  endfunction

  initial begin
    int nrsp1, peak;
    chks = 0; errs = 0; cyc = 0; pm = 0; g_m = -1;
    rst = 1; req_valid = 0; flush = 0; req_tag = 0; req_x = 0; req_y = 0;
    @(posedge clk); #1;

    // reset, single issue, flush of in-flight work, flush on retire, reset mid-operation
    tv.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 2'b01, 2'b00, 3, 0, 2'b01, 2'b00, 0, 0));
    for (int i = 0; i < 4; i++) tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1));
    tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b01, 3, 1));
    tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0));
    tv.push_back(mk(0, 2'b01, 2'b00, 1, 0, 2'b01, 2'b00, 0, 1));
    tv.push_back(mk(0, 2'b01, 2'b00, 2, 0, 2'b01, 2'b00, 0, 2));
    tv.push_back(mk(0, 2'b11, 2'b01, 0, 5, 2'b10, 2'b00, 0, 3));
    for (int i = 0; i < 4; i++) tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1));
    tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b10, 5, 1));
    tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 2'b01, 2'b00, 7, 0, 2'b01, 2'b00, 0, 0));
    for (int i = 0; i < 4; i++) tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1));
    tv.push_back(mk(0, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00, 0, 1));
    tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 2'b11, 2'b00, 1, 2, 2'b10, 2'b00, 0, 0));
    tv.push_back(mk(0, 2'b11, 2'b00, 1, 2, 2'b01, 2'b00, 0, 1));
    tv.push_back(mk(0, 2'b11, 2'b00, 1, 2, 2'b10, 2'b00, 0, 2));
    tv.push_back(mk(1, 2'b11, 2'b00, 1, 2, 2'b00, 2'b00, 0, 3));
    for (int i = 0; i < 6; i++) tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 2'b11, 2'b00, 1, 2, 2'b01, 2'b00, 0, 0));

    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].v, tv[i].f, tv[i].t0, tv[i].t1,
            32'h4000_0000, 32'(i), 32'h3f80_0000, ~32'(i));
      chk("tv_ready", 32'(req_ready), 32'(tv[i].rdy));
      chk("tv_rsp_valid", 32'(rsp_valid), 32'(tv[i].rsp));
      if (tv[i].rsp != 0) chk("tv_rsp_tag", 32'(rsp_tag), 32'(tv[i].tag));
      chk("tv_inflight", 32'(inflight), 32'(tv[i].inf));
      tick();
    end

    // contention from reset: grants alternate 0,1,0,1
    drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0); tick();
    for (int k = 0; k < 10; k++) begin
      drive(0, 2'b11, 2'b00, 4'(k), 4'(k + 8), $urandom, $urandom, $urandom, $urandom);
      chk("rr_alternate", 32'(req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
      tick();
    end
    for (int k = 0; k < 7; k++) begin drive(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0); tick(); end

    // streaming on requester 1
    drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0); tick();
    nrsp1 = 0; peak = 0;
    for (int k = 0; k < 16; k++) begin
      drive(0, (k < 8) ? 2'b10 : 2'b00, 2'b00, 0, 4'(k), 0, 0, $urandom, $urandom);
      if (rsp_valid[1]) begin
        chk("stream_tag", 32'(rsp_tag), 32'(nrsp1));
        nrsp1++;
      end
      if (int'(inflight) > peak) peak = int'(inflight);
      tick();
    end
    chk("stream_count", 32'(nrsp1), 32'd8);
    chk("stream_peak_inflight", 32'(peak), 32'(LAT));

    // random traffic with occasional flushes and resets
    for (int k = 0; k < 600; k++) begin
      drive(($urandom % 64) == 0, 2'($urandom),
            {($urandom % 8) == 0, ($urandom % 8) == 0},
            4'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom);
      tick();
    end
    for (int k = 0; k < 8; k++) begin drive(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0); tick(); end

    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end
endmodule
